axil_reg_slave: RTL and testbench

- AXI4-Lite responder (slave) holding C_NUM_REGS 32-bit read/write registers plus one read-only status word.
- Sits behind an AXI4-Lite master such as the master VIP in our BFM benches, or the PS GP port in the integration block design.
- Register contents are exported to fabric logic, with a one-cycle write pulse per register.

---
 rtl/axil_reg_slave_if.sv | 37 +++
 rtl/axil_reg_slave.sv | 147 ++++++++++++++
 tb/tb_axil_reg_slave.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/axil_reg_slave_if.sv
// AXI4-Lite bus bundle for the register slave: five channels plus master/slave views.
interface axil_reg_slave_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0]   awaddr;
    logic [2:0]          awprot;
    logic                awvalid;
    logic                awready;
    logic [DATA_W-1:0]   wdata;
    logic [DATA_W/8-1:0] wstrb;
    logic                wvalid;
    logic                wready;
    logic [1:0]          bresp;
    logic                bvalid;
    logic                bready;
    logic [ADDR_W-1:0]   araddr;
    logic [2:0]          arprot;
    logic                arvalid;
    logic                arready;
    logic [DATA_W-1:0]   rdata;
    logic [1:0]          rresp;
    logic                rvalid;
    logic                rready;

    modport master (
        output awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  awaddr, awprot, awvalid, wdata, wstrb, wvalid, bready,
               araddr, arprot, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );
endinterface

// File: rtl/axil_reg_slave.sv
// AXI4-Lite register slave: C_NUM_REGS R/W words plus a read-only count of accepted writes,
// with independent AW/W holding buffers and per-register write pulses to fabric.
module axil_reg_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int C_NUM_REGS         = 4
) (
    input  logic                     S_AXI_ACLK,
    input  logic                     S_AXI_ARESETN,
    axil_reg_slave_if.slave          s_axi,
    output logic [C_NUM_REGS*32-1:0] reg_out,
    output logic [C_NUM_REGS-1:0]    reg_wr_pulse
);
    localparam int IDX_W = C_S_AXI_ADDR_WIDTH - 2;
    localparam logic [IDX_W-1:0] STATUS_IDX = IDX_W'(C_NUM_REGS);

    typedef enum logic [1:0] {
        RESP_OKAY   = 2'b00,
        RESP_SLVERR = 2'b10
    } resp_e;

    logic             init_done;
    logic             aw_held;
    logic             w_held;
    logic [IDX_W-1:0] aw_idx_q;
    logic [31:0]      w_data_q;
    logic [3:0]       w_strb_q;
    logic [31:0]      regs [C_NUM_REGS];
    logic [31:0]      status_cnt;

    logic             aw_hs, w_hs, ar_hs, commit, wr_ok;
    logic [IDX_W-1:0] wr_idx, rd_idx;
    logic [31:0]      wr_data, rd_value;
    logic [3:0]       wr_strb;
    resp_e            rd_resp;

    logic unused_inputs;
    assign unused_inputs = ^{s_axi.awprot, s_axi.arprot, s_axi.awaddr[1:0], s_axi.araddr[1:0]};

    assign s_axi.awready = init_done & ~aw_held & ~s_axi.bvalid;
    assign s_axi.wready  = init_done & ~w_held & ~s_axi.bvalid;
    assign s_axi.arready = init_done & ~s_axi.rvalid;

    assign aw_hs = s_axi.awvalid & s_axi.awready;
    assign w_hs  = s_axi.wvalid & s_axi.wready;
    assign ar_hs = s_axi.arvalid & s_axi.arready;

    // Commit on the edge where the second half of the write arrives, using held or live values.
    assign commit  = (aw_held | aw_hs) & (w_held | w_hs);
    assign wr_idx  = aw_held ? aw_idx_q : s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
    assign wr_data = w_held ? w_data_q : s_axi.wdata;
    assign wr_strb = w_held ? w_strb_q : s_axi.wstrb;
    assign wr_ok   = wr_idx < STATUS_IDX;
    assign rd_idx  = s_axi.araddr[C_S_AXI_ADDR_WIDTH-1:2];

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        rd_value = '0;
        rd_resp  = RESP_SLVERR;
        if (rd_idx == STATUS_IDX) begin
            rd_value = status_cnt;
            rd_resp  = RESP_OKAY;
        end
        for (int k = 0; k < C_NUM_REGS; k++) begin
            if (rd_idx == IDX_W'(k)) begin
                rd_value = regs[k];
                rd_resp  = RESP_OKAY;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            init_done    <= 1'b0;
            aw_held      <= 1'b0;
            w_held       <= 1'b0;
            aw_idx_q     <= '0;
            w_data_q     <= '0;
            w_strb_q     <= '0;
            s_axi.bvalid <= 1'b0;
            s_axi.bresp  <= RESP_OKAY;
            s_axi.rvalid <= 1'b0;
            s_axi.rdata  <= '0;
            s_axi.rresp  <= RESP_OKAY;
        end else begin
            init_done <= 1'b1;
            if (commit) begin
                aw_held      <= 1'b0;
                w_held       <= 1'b0;
                s_axi.bvalid <= 1'b1;
                s_axi.bresp  <= wr_ok ? RESP_OKAY : RESP_SLVERR;
            end else begin
                if (aw_hs) begin
                    aw_held  <= 1'b1;
                    aw_idx_q <= s_axi.awaddr[C_S_AXI_ADDR_WIDTH-1:2];
                end
                if (w_hs) begin
                    w_held   <= 1'b1;
                    w_data_q <= s_axi.wdata;
                    w_strb_q <= s_axi.wstrb;
                end
                if (s_axi.bvalid && s_axi.bready) begin
                    s_axi.bvalid <= 1'b0;
                end
            end

            if (ar_hs) begin
                s_axi.rvalid <= 1'b1;
                s_axi.rdata  <= rd_value;
                s_axi.rresp  <= rd_resp;
            end else if (s_axi.rvalid && s_axi.rready) begin
                s_axi.rvalid <= 1'b0;
            end
        end
    end

    // NOTE: the register file is small and its contents are exported, so it is reset like any flop.
    always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
        if (!S_AXI_ARESETN) begin
            for (int k = 0; k < C_NUM_REGS; k++) begin
                regs[k] <= '0;
            end
            reg_wr_pulse <= '0;
            status_cnt   <= '0;
        end else begin
            reg_wr_pulse <= '0;
            if (commit && wr_ok) begin
                status_cnt <= status_cnt + 32'd1;
                for (int k = 0; k < C_NUM_REGS; k++) begin
                    if (wr_idx == IDX_W'(k)) begin
                        reg_wr_pulse[k] <= 1'b1;
                        for (int b = 0; b < 4; b++) begin
                            if (wr_strb[b]) begin
                                regs[k][8*b +: 8] <= wr_data[8*b +: 8];
                            end
                        end
                    end
                end
            end
        end
    end

    for (genvar k = 0; k < C_NUM_REGS; k++) begin : g_reg_out
        assign reg_out[32*k +: 32] = regs[k];
    end
endmodule

// File: tb/tb_axil_reg_slave.sv
// Self-checking bench for axil_reg_slave: directed corner cases plus randomized
// transactions compared against an array-based register model.
module tb_axil_reg_slave;
    localparam int AW    = 5;
    localparam int NREGS = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    axil_reg_slave_if #(.ADDR_W(AW), .DATA_W(32)) s_axi ();
    logic [NREGS*32-1:0] reg_out;
    logic [NREGS-1:0]    reg_wr_pulse;

    axil_reg_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(AW),
        .C_NUM_REGS(NREGS)
    ) dut (
        .S_AXI_ACLK(clk),
        .S_AXI_ARESETN(rst_n),
        .s_axi(s_axi),
        .reg_out(reg_out),
        .reg_wr_pulse(reg_wr_pulse)
    );

    logic [31:0] m_regs [NREGS];
    logic [31:0] m_status;
    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [1:0] m_wresp(input int idx);
        return (idx < NREGS) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [1:0] m_rresp(input int idx);
        return (idx <= NREGS) ? 2'b00 : 2'b10;
    endfunction

    function automatic logic [31:0] m_read(input int idx);
        if (idx < NREGS) return m_regs[idx];
        if (idx == NREGS) return m_status;
        return 32'd0;
    endfunction

    function automatic logic [127:0] m_packed();
        logic [127:0] p = '0;
        for (int k = 0; k < NREGS; k++) p[32*k +: 32] = m_regs[k];
        return p;
    endfunction

    task automatic m_write(input int idx, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        if (idx < NREGS) begin
            for (int b = 0; b < 4; b++) begin
                if (s[b]) begin
                    mask = 32'hFF << (8 * b);
                    m_regs[idx] = (m_regs[idx] & ~mask) | (d & mask);
                end
            end
            m_status = m_status + 32'd1;
        end
    endtask

    task automatic m_clear();
        for (int k = 0; k < NREGS; k++) m_regs[k] = '0;
        m_status = '0;
    endtask

    // All tasks start and end at posedge+1, so inputs change and outputs are sampled away from the edge.
    task automatic axi_write(input logic [AW-1:0] addr, input logic [31:0] data, input logic [3:0] strb,
                             input int aw_dly, input int w_dly, input int b_dly);
        int idx = int'(addr[AW-1:2]);
        int cyc = 0;
        bit aw_done = 0, w_done = 0, aw_now, w_now;
        logic [NREGS-1:0] exp_pulse;
        s_axi.awaddr = addr;
        s_axi.awprot = 3'($urandom);
        s_axi.wdata  = data;
        s_axi.wstrb  = strb;
        while (!(aw_done && w_done) && cyc < 40) begin
            s_axi.awvalid = !aw_done && cyc >= aw_dly;
            s_axi.wvalid  = !w_done && cyc >= w_dly;
            aw_now = s_axi.awvalid && s_axi.awready;
            w_now  = s_axi.wvalid && s_axi.wready;
            @(posedge clk); #1;
            aw_done |= aw_now;
            w_done  |= w_now;
            cyc++;
            if (!(aw_done && w_done)) begin
                check("bvalid_before_both", s_axi.bvalid, 1'b0);
                if (aw_done) check("awready_while_held", s_axi.awready, 1'b0);
                if (w_done)  check("wready_while_held", s_axi.wready, 1'b0);
            end
        end
        s_axi.awvalid = 1'b0;
        s_axi.wvalid  = 1'b0;
        check("write_handshake_done", aw_done && w_done, 1'b1);

        m_write(idx, data, strb);
        exp_pulse = (idx < NREGS) ? (NREGS'(1) << idx) : '0;
        check("bvalid_latency", s_axi.bvalid, 1'b1);
        check("bresp", s_axi.bresp, m_wresp(idx));
        check("wr_pulse", reg_wr_pulse, exp_pulse);
        check("reg_out", reg_out, m_packed());
        for (int i = 0; i < b_dly; i++) begin
            @(posedge clk); #1;
            check("bvalid_hold", s_axi.bvalid, 1'b1);
            check("bresp_hold", s_axi.bresp, m_wresp(idx));
            check("aw_w_ready_blocked", {s_axi.awready, s_axi.wready}, 2'b00);
            check("wr_pulse_single", reg_wr_pulse, '0);
        end
        s_axi.bready = 1'b1;
        @(posedge clk); #1;
        s_axi.bready = 1'b0;
        check("bvalid_drop", s_axi.bvalid, 1'b0);
        check("aw_w_ready_after_b", {s_axi.awready, s_axi.wready}, 2'b11);
        check("wr_pulse_clear", reg_wr_pulse, '0);
    endtask

    task automatic axi_read(input logic [AW-1:0] addr, input int r_dly, output logic [31:0] rd);
        int idx = int'(addr[AW-1:2]);
        int cyc = 0;
        logic [31:0] exp_d;
        logic [1:0]  exp_r;
        s_axi.araddr  = addr;
        s_axi.arprot  = 3'($urandom);
        s_axi.arvalid = 1'b1;
        while (!s_axi.arready && cyc < 40) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("arready_wait", s_axi.arready, 1'b1);
        exp_d = m_read(idx);
        exp_r = m_rresp(idx);
        @(posedge clk); #1;
        s_axi.arvalid = 1'b0;
        rd = s_axi.rdata;
        check("rvalid_latency", s_axi.rvalid, 1'b1);
        check("rdata", s_axi.rdata, exp_d);
        check("rresp", s_axi.rresp, exp_r);
        for (int i = 0; i < r_dly; i++) begin
            @(posedge clk); #1;
            check("rvalid_hold", s_axi.rvalid, 1'b1);
            check("rdata_hold", s_axi.rdata, exp_d);
            check("arready_blocked", s_axi.arready, 1'b0);
        end
        s_axi.rready = 1'b1;
        @(posedge clk); #1;
        s_axi.rready = 1'b0;
        check("rvalid_drop", s_axi.rvalid, 1'b0);
        check("arready_after_r", s_axi.arready, 1'b1);
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        #1;
        m_clear();
        check("rst_readies", {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b000);
        check("rst_valids", {s_axi.bvalid, s_axi.rvalid}, 2'b00);
        check("rst_resp", {s_axi.bresp, s_axi.rresp}, 4'b0000);
        check("rst_rdata", s_axi.rdata, 32'd0);
        check("rst_reg_out", reg_out, m_packed());
        check("rst_pulse", reg_wr_pulse, '0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_readies_held", {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b000);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("readies_before_edge", {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b000);
        @(posedge clk); #1;
        check("readies_after_release", {s_axi.awready, s_axi.wready, s_axi.arready}, 3'b111);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, observed timeout, required completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [31:0] rd, old;
        logic [AW-1:0] ra;
        s_axi.awaddr = '0; s_axi.awprot = '0; s_axi.awvalid = 1'b0;
        s_axi.wdata = '0; s_axi.wstrb = '0; s_axi.wvalid = 1'b0; s_axi.bready = 1'b0;
        s_axi.araddr = '0; s_axi.arprot = '0; s_axi.arvalid = 1'b0; s_axi.rready = 1'b0;
        m_clear();
        #1;
        apply_reset();

        for (int k = 0; k < NREGS; k++) axi_write(AW'(4 * k), 32'(k + 1), 4'hF, 0, 0, 0);
        for (int k = 0; k < NREGS; k++) begin
            axi_read(AW'(4 * k), 0, rd);
            check("directed_readback", rd, 32'(k + 1));
        end
        axi_read(5'h10, 0, rd);
        check("status_after_four", rd, 32'd4);

        axi_write(5'h04, 32'hAABBCCDD, 4'hF, 0, 0, 0);
        axi_write(5'h05, 32'h11223344, 4'b0101, 0, 0, 0);
        axi_read(5'h06, 0, rd);
        check("strb_merge", rd, 32'hAA22CC44);

        axi_write(5'h08, $urandom, 4'hF, 0, 3, 0);
        axi_write(5'h0C, $urandom, 4'hF, 3, 0, 0);
        axi_read(5'h08, 0, rd);
        axi_read(5'h0C, 0, rd);

        axi_write(5'h00, $urandom, 4'hF, 0, 0, 5);
        axi_write(5'h04, $urandom, 4'hF, 0, 0, 0);
        axi_read(5'h00, 5, rd);

        old = m_status;
        axi_write(5'h10, $urandom, 4'hF, 0, 0, 0);
        axi_write(5'h14, $urandom, 4'hF, 1, 0, 0);
        axi_read(5'h14, 0, rd);
        axi_read(5'h10, 0, rd);
        check("status_unchanged_on_slverr", rd, old);

        for (int n = 0; n < 40; n++) begin
            axi_write({3'($urandom_range(0, 7)), 2'($urandom)}, $urandom, 4'($urandom),
                      $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
            ra = {3'($urandom_range(0, 7)), 2'($urandom)};
            axi_read(ra, $urandom_range(0, 2), rd);
        end

        // Write and read of reg 0 on the same edge, then reset with both responses pending.
        old = m_regs[0];
        s_axi.awaddr = 5'h00; s_axi.wdata = 32'hDEAD_BEEF; s_axi.wstrb = 4'hF;
        s_axi.araddr = 5'h00;
        s_axi.awvalid = 1'b1; s_axi.wvalid = 1'b1; s_axi.arvalid = 1'b1;
        @(posedge clk); #1;
        s_axi.awvalid = 1'b0; s_axi.wvalid = 1'b0; s_axi.arvalid = 1'b0;
        check("collision_pending", {s_axi.bvalid, s_axi.rvalid}, 2'b11);
        check("collision_old_value", s_axi.rdata, old);
        check("collision_new_reg", reg_out[31:0], 32'hDEAD_BEEF);
        apply_reset();
        axi_read(5'h00, 0, rd);
        check("no_spurious_b", s_axi.bvalid, 1'b0);

        // Reset with an address held but no data: the held entry must not survive.
        s_axi.awaddr = 5'h08;
        s_axi.awvalid = 1'b1;
        @(posedge clk); #1;
        s_axi.awvalid = 1'b0;
        check("aw_held_before_reset", s_axi.awready, 1'b0);
        apply_reset();
        axi_write(5'h08, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
        axi_read(5'h08, 0, rd);
        axi_read(5'h10, 0, rd);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
